// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS control FSM (addu, subu, ori, lui, lw, sw, beq, j) driving the shared datapath.
// Optional memory handshake: define MULTICYCLE_MEM_WAIT_EN to stall FETCH/MEM_RD/MEM_WR on mem_ready.
//
// state    | meaning
// FETCH    | read instruction at PC, IR <= mem, PC <= PC + 4
// DECODE   | classify opcode, ALUOut <= branch target
// MEM_ADDR | effective address for lw/sw
// MEM_RD   | data read at ALUOut
// MEM_WB   | rt <= MDR
// MEM_WR   | data write at ALUOut
// EXEC_R   | rs op rt
// WB_R     | rd <= ALUOut
// EXEC_I   | rs op imm (ori/lui)
// WB_I     | rt <= ALUOut
// BRANCH   | compare rs/rt, PC <= ALUOut if equal
// JUMP     | PC <= jump target
// HALT     | illegal instruction seen, parked until reset
module multicycle_ctrl #(
  parameter int STATE_W         = 4,
  parameter bit HALT_ON_ILLEGAL = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [5:0]         opcode,
  input  logic [5:0]         funct,
  input  logic               mem_ready,
  output logic               pc_write,
  output logic               pc_write_cond,
  output logic [1:0]         pc_source,
  output logic               ir_write,
  output logic               i_or_d,
  output logic               mem_read,
  output logic               mem_write,
  output logic               mem_to_reg,
  output logic               reg_dst,
  output logic               reg_write,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         alu_op,
  output logic [1:0]         ext_op,
  output logic               instr_done,
  output logic               illegal,
  output logic [STATE_W-1:0] state_o
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEM_ADDR = 4'd2,
    MEM_RD   = 4'd3,
    MEM_WB   = 4'd4,
    MEM_WR   = 4'd5,
    EXEC_R   = 4'd6,
    WB_R     = 4'd7,
    EXEC_I   = 4'd8,
    WB_I     = 4'd9,
    BRANCH   = 4'd10,
    JUMP     = 4'd11,
    HALT     = 4'd15
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  state_t state_q, state_d;
  logic   illegal_q;
  logic   mem_go;
  logic   is_mem, is_r, is_i, is_beq, is_j, is_legal;

`ifdef MULTICYCLE_MEM_WAIT_EN
  assign mem_go = mem_ready;
`else
  logic unused_mem_ready;
  assign unused_mem_ready = mem_ready;
  assign mem_go = 1'b1;
`endif

  assign is_mem   = (opcode == OP_LW) || (opcode == OP_SW);
  assign is_r     = (opcode == OP_RTYPE) && ((funct == 6'b100001) || (funct == 6'b100011));
  assign is_i     = (opcode == OP_ORI) || (opcode == OP_LUI);
  assign is_beq   = (opcode == OP_BEQ);
  assign is_j     = (opcode == OP_J);
  assign is_legal = is_mem || is_r || is_i || is_beq || is_j;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == DECODE && !is_legal) illegal_q <= 1'b1;
    end
  end

  always_comb begin
    state_d       = state_q;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_source     = 2'b00;
    ir_write      = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    ext_op        = 2'b00;
    instr_done    = 1'b0;
    case (state_q)
      FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        if (mem_go) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = DECODE;
        end
      end
      DECODE: begin
        alu_src_b = 2'b11;
        ext_op    = 2'b01;
        if (is_mem)      state_d = MEM_ADDR;
        else if (is_r)   state_d = EXEC_R;
        else if (is_i)   state_d = EXEC_I;
        else if (is_beq) state_d = BRANCH;
        else if (is_j)   state_d = JUMP;
        else             state_d = HALT_ON_ILLEGAL ? HALT : FETCH;
      end
      MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        ext_op    = 2'b01;
        state_d   = (opcode == OP_LW) ? MEM_RD : MEM_WR;
      end
      MEM_RD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        if (mem_go) state_d = MEM_WB;
      end
      MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
        state_d    = FETCH;
      end
      MEM_WR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
        if (mem_go) begin
          instr_done = 1'b1;
          state_d    = FETCH;
        end
      end
      EXEC_R: begin
        alu_src_a = 1'b1;
        alu_op    = funct[1] ? 2'b01 : 2'b00;
        state_d   = WB_R;
      end
      WB_R: begin
        reg_write  = 1'b1;
        reg_dst    = 1'b1;
        instr_done = 1'b1;
        state_d    = FETCH;
      end
      EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        if (opcode == OP_ORI) begin
          ext_op = 2'b00;
          alu_op = 2'b10;
        end else begin
          ext_op = 2'b10;
          alu_op = 2'b11;
        end
        state_d = WB_I;
      end
      WB_I: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_d    = FETCH;
      end
      BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'b01;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
        instr_done    = 1'b1;
        state_d       = FETCH;
      end
      JUMP: begin
        pc_write   = 1'b1;
        pc_source  = 2'b10;
        instr_done = 1'b1;
        state_d    = FETCH;
      end
      HALT:    state_d = HALT;
      default: state_d = FETCH;
    endcase
    // The reset state is FETCH, whose strobes must stay quiet while reset is held.
    if (!rst_n) begin
      pc_write   = 1'b0;
      ir_write   = 1'b0;
      mem_read   = 1'b0;
      alu_src_b  = 2'b00;
    end
  end

  assign illegal = illegal_q;
  assign state_o = STATE_W'(state_q);

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: per-instruction state-path model checked every cycle, plus directed literal checks.
module tb_multicycle_ctrl;

`ifdef MULTICYCLE_MEM_WAIT_EN
  localparam bit MEMWAIT = 1'b1;
`else
  localparam bit MEMWAIT = 1'b0;
`endif
  localparam bit HALT_ILL = 1'b1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode, funct;
  logic       mem_ready;
  logic       pc_write, pc_write_cond, ir_write, i_or_d, mem_read, mem_write;
  logic       mem_to_reg, reg_dst, reg_write, alu_src_a, instr_done, illegal;
  logic [1:0] pc_source, alu_src_b, alu_op, ext_op;
  logic [3:0] state_o;
  logic [23:0] dut_vec;

  int checks = 0;
  int errors = 0;

  multicycle_ctrl #(.STATE_W(4), .HALT_ON_ILLEGAL(HALT_ILL)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_source(pc_source),
    .ir_write(ir_write), .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .ext_op(ext_op),
    .instr_done(instr_done), .illegal(illegal), .state_o(state_o)
  );

  always #5 clk = ~clk;

  assign dut_vec = {pc_write, pc_write_cond, pc_source, ir_write, i_or_d, mem_read, mem_write,
                    mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, ext_op,
                    instr_done, illegal, state_o};

  // Row per instruction class: [0] = length, then the state visited in each cycle.
  // Classes: 0 illegal, 1 lw, 2 sw, 3 R-type, 4 ori/lui, 5 beq, 6 j.
  int path_tbl [7][6] = '{
    '{(HALT_ILL ? 3 : 2), 0, 1, 15, 0, 0},
    '{5, 0, 1, 2, 3, 4},
    '{4, 0, 1, 2, 5, 0},
    '{4, 0, 1, 6, 7, 0},
    '{4, 0, 1, 8, 9, 0},
    '{3, 0, 1, 10, 0, 0},
    '{3, 0, 1, 11, 0, 0}
  };

  int m_step = 0;
  bit m_halt = 1'b0;
  bit m_ill  = 1'b0;

  function automatic int cls(logic [5:0] op, logic [5:0] fn);
    if (op == 6'b100011) return 1;
    if (op == 6'b101011) return 2;
    if (op == 6'b000000 && (fn == 6'b100001 || fn == 6'b100011)) return 3;
    if (op == 6'b001101 || op == 6'b001111) return 4;
    if (op == 6'b000100) return 5;
    if (op == 6'b000010) return 6;
    return 0;
  endfunction

  function automatic int cur_state();
    if (m_halt) return 15;
    return path_tbl[cls(opcode, funct)][m_step + 1];
  endfunction

  function automatic logic [23:0] expect_out(int st, logic [5:0] op, logic [5:0] fn,
                                             logic rdy, logic rstn, logic ill);
    logic pw, pwc, irw, iod, mr, mw, m2r, rd, rw, sa, done, go;
    logic [1:0] ps, sb, aop, ext;
    {pw, pwc, irw, iod, mr, mw, m2r, rd, rw, sa, done} = '0;
    {ps, sb, aop, ext} = '0;
    go = MEMWAIT ? rdy : 1'b1;
    if (!rstn) return '0;
    case (st)
      0:  begin mr = 1; sb = 2'b01; irw = go; pw = go; end
      1:  begin sb = 2'b11; ext = 2'b01; end
      2:  begin sa = 1; sb = 2'b10; ext = 2'b01; end
      3:  begin mr = 1; iod = 1; end
      4:  begin rw = 1; m2r = 1; done = 1; end
      5:  begin mw = 1; iod = 1; done = go; end
      6:  begin sa = 1; aop = (fn == 6'b100011) ? 2'b01 : 2'b00; end
      7:  begin rw = 1; rd = 1; done = 1; end
      8:  begin
            sa = 1; sb = 2'b10;
            if (op == 6'b001101) begin ext = 2'b00; aop = 2'b10; end
            else begin ext = 2'b10; aop = 2'b11; end
          end
      9:  begin rw = 1; done = 1; end
      10: begin sa = 1; aop = 2'b01; pwc = 1; ps = 2'b01; done = 1; end
      11: begin pw = 1; ps = 2'b10; done = 1; end
      default: ;
    endcase
    return {pw, pwc, ps, irw, iod, mr, mw, m2r, rd, rw, sa, sb, aop, ext, done, ill, 4'(st)};
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  always @(posedge clk) begin
    int c, st;
    if (!rst_n) begin
      m_step = 0; m_halt = 1'b0; m_ill = 1'b0;
    end else if (!m_halt) begin
      c  = cls(opcode, funct);
      st = cur_state();
      if (!(MEMWAIT && (st == 0 || st == 3 || st == 5) && !mem_ready)) begin
        if (st == 1 && c == 0) m_ill = 1'b1;
        m_step++;
        if (m_step >= path_tbl[c][0]) m_step = 0;
        else if (path_tbl[c][m_step + 1] == 15) m_halt = 1'b1;
      end
    end
  end

  always @(negedge clk)
    chk("cycle outputs", 32'(dut_vec),
        32'(expect_out(cur_state(), opcode, funct, mem_ready, rst_n, m_ill)));

  int seen[$];
  int n_done, n_irw;

  task automatic run_instr(string name, logic [5:0] op, logic [5:0] fn,
                           int fw, int rw, int exp_cyc);
    int fcnt, rcnt, cycles;
    bit left;
    opcode = op; funct = fn;
    fcnt = 0; rcnt = 0; cycles = 0; left = 0; n_done = 0; n_irw = 0;
    seen.delete();
    for (int i = 0; i < 40; i++) begin
      if (state_o == 0 && fcnt < fw) begin mem_ready = 0; fcnt++; end
      else if ((state_o == 3 || state_o == 5) && rcnt < rw) begin mem_ready = 0; rcnt++; end
      else mem_ready = 1;
      #1;
      seen.push_back(int'(state_o));
      n_done += int'(instr_done);
      n_irw  += int'(ir_write);
      @(posedge clk); #1;
      cycles++;
      if (state_o != 0) left = 1;
      else if (left) break;
    end
    seen.push_back(int'(state_o));
    mem_ready = 1;
    chk({name, " cycles"}, cycles, exp_cyc);
    chk({name, " instr_done count"}, n_done, 1);
    chk({name, " ir_write count"}, n_irw, 1);
  endtask

  initial begin
    int exp_r [5] = '{0, 1, 6, 7, 0};
    int k;
    rst_n = 0; opcode = 0; funct = 0; mem_ready = 1;
    #3;
    chk("reset state_o", state_o, 0);
    chk("reset mem_read", mem_read, 0);
    chk("reset illegal", illegal, 0);
    repeat (3) @(posedge clk);
    @(negedge clk); #2 rst_n = 1;

    run_instr("addu", 6'b000000, 6'b100001, 0, 0, 4);
    chk("addu path length", seen.size(), 5);
    foreach (exp_r[i]) if (i < seen.size()) chk("addu path state", seen[i], exp_r[i]);

    run_instr("lw", 6'b100011, 6'b000000, 3, 2, MEMWAIT ? 10 : 5);
    run_instr("sw", 6'b101011, 6'b000000, 0, 0, 4);
    run_instr("beq", 6'b000100, 6'b000000, 0, 0, 3);
    run_instr("j", 6'b000010, 6'b000000, 0, 0, 3);
    run_instr("ori", 6'b001101, 6'b000000, 0, 0, 4);
    run_instr("lui", 6'b001111, 6'b000000, 0, 0, 4);
    run_instr("subu", 6'b000000, 6'b100011, 0, 0, 4);
    run_instr("sw wait", 6'b101011, 6'b000000, 1, 2, MEMWAIT ? 7 : 4);

    // Reset in the middle of a load (mid-wait when the handshake is built in).
    opcode = 6'b100011; funct = 0; mem_ready = 1;
    repeat (3) @(posedge clk); #1;
    chk("midreset pre state", state_o, 3);
    mem_ready = 0;
    @(posedge clk); #1;
    chk("midreset wait state", state_o, MEMWAIT ? 3 : 4);
    rst_n = 0; #1;
    chk("midreset outputs", 32'(dut_vec), 0);
    repeat (2) @(posedge clk);
    @(negedge clk); #2 rst_n = 1; mem_ready = 1;

    // Illegal opcode parks in HALT with the sticky flag.
    opcode = 6'b111111; funct = 0;
    k = 0;
    while (state_o != 15 && k < 10) begin @(posedge clk); #1; k++; end
    chk("illegal reaches halt", state_o, 15);
    chk("illegal flag", illegal, 1);
    repeat (20) @(posedge clk); #1;
    chk("halt held state", state_o, 15);
    chk("halt held illegal", illegal, 1);
    chk("halt no done", instr_done, 0);
    @(negedge clk); #2 rst_n = 0; #1;
    chk("halt reset illegal", illegal, 0);
    chk("halt reset state", state_o, 0);
    repeat (2) @(posedge clk);
    @(negedge clk); #2 rst_n = 1; #1;
    chk("after release illegal", illegal, 0);
    chk("after release fetch read", mem_read, 1);
    run_instr("addu after halt", 6'b000000, 6'b100001, 0, 0, 4);

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multi-cycle MIPS control FSM that sequences the shared datapath: one memory, one ALU, register file, IR, ALUOut and PC registers.
- Decodes opcode/funct from the IR and drives per-state control strobes.
- Supported instructions: addu, subu, ori, lui, lw, sw, beq, j.
- Sits beside the datapath and replaces single-cycle decode for the multi-cycle CPU.

Parameters:
- STATE_W, 4, width of state register and state_o
- HALT_ON_ILLEGAL, 1, 1 = illegal instruction enters HALT; 0 = treated as NOP (FETCH next)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- opcode  in  6  IR[31:26]
- funct  in  6  IR[5:0]
- mem_ready  in  1  memory access complete (used only with MEM_WAIT_EN)
- pc_write  out  1  unconditional PC load
- pc_write_cond  out  1  PC load if ALU zero (datapath ANDs with zero)
- pc_source  out  2  00 ALU result, 01 ALUOut, 10 jump target
- ir_write  out  1  IR load
- i_or_d  out  1  0 = PC addresses memory, 1 = ALUOut addresses memory
- mem_read  out  1  memory read strobe
- mem_write  out  1  memory write strobe
- mem_to_reg  out  1  1 = MDR to register file
- reg_dst  out  1  1 = rd, 0 = rt
- reg_write  out  1  register file write enable
- alu_src_a  out  1  0 = PC, 1 = register A
- alu_src_b  out  2  00 B, 01 const 4, 10 ext imm, 11 sign-ext imm<<2
- alu_op  out  2  00 ADD, 01 SUB, 10 OR, 11 LUI
- ext_op  out  2  00 zero, 01 sign, 10 upper (imm<<16)
- instr_done  out  1  one-cycle pulse on final state of each instruction
- illegal  out  1  sticky illegal-instruction flag
- state_o  out  STATE_W  current state, for debug

Behaviour:
- State encoding: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_RD=3, MEM_WB=4, MEM_WR=5, EXEC_R=6, WB_R=7, EXEC_I=8, WB_I=9, BRANCH=10, JUMP=11, HALT=15. Any other value goes to FETCH.
- State register is async reset to FETCH. Outputs are Moore, decoded from the state.
- While rst_n=0, every output is 0 (state_o=0, illegal=0). The first FETCH strobes occur in the first clk edge cycle after release. Reset mid-instruction aborts it with no memory or register write.
- Any output not listed for a state is 0.
- FETCH: mem_read, ir_write, pc_write, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=ADD. Next: DECODE.
- DECODE: alu_src_a=0, alu_src_b=11, ext_op=01, alu_op=ADD (branch target to ALUOut). Next state by opcode:
  - 100011 or 101011: MEM_ADDR
  - 000000 with funct 100001 or 100011: EXEC_R
  - 001101 or 001111: EXEC_I
  - 000100: BRANCH
  - 000010: JUMP
  - otherwise: illegal. illegal<=1 (sticky until reset); next is HALT if HALT_ON_ILLEGAL, else FETCH.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, ext_op=01, ADD. Next: MEM_RD if opcode=100011, else MEM_WR.
- MEM_RD: mem_read, i_or_d=1. Next: MEM_WB.
- MEM_WB: reg_write, reg_dst=0, mem_to_reg=1, instr_done. Next: FETCH.
- MEM_WR: mem_write, i_or_d=1, instr_done. Next: FETCH.
- EXEC_R: alu_src_a=1, alu_src_b=00, alu_op = funct[1] ? SUB : ADD. Next: WB_R.
- WB_R: reg_write, reg_dst=1, instr_done. Next: FETCH.
- EXEC_I: alu_src_a=1, alu_src_b=10. ori: ext_op=00, alu_op=OR. lui: ext_op=10, alu_op=LUI. Next: WB_I.
- WB_I: reg_write, reg_dst=0, instr_done. Next: FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, SUB, pc_write_cond, pc_source=01, instr_done. Next: FETCH.
- JUMP: pc_write, pc_source=10, instr_done. Next: FETCH.
- HALT: all strobes 0, illegal=1. Stays in HALT until reset.
- Latency in cycles: lw 5, sw 4, R-type 4, ori/lui 4, beq 3, j 3.
- opcode/funct are sampled only in DECODE, MEM_ADDR, EXEC_R and EXEC_I. The IR is stable after FETCH.

Optional Feature:
- Macro: MULTICYCLE_MEM_WAIT_EN.
- Defined: FETCH, MEM_RD and MEM_WR hold their state and strobes until mem_ready=1.
  - In FETCH, ir_write and pc_write assert only in the mem_ready=1 cycle.
  - In MEM_WR, instr_done asserts only in the mem_ready=1 cycle.
  - An arbitrary number of wait cycles is allowed. Reset during a wait returns to FETCH.
- Undefined: mem_ready is ignored; every memory state lasts exactly 1 cycle.

Test Plan:
- Reset release, opcode=000000, funct=100001 -> states 0,1,6,7,0. WB_R has reg_write=1, reg_dst=1, instr_done=1. alu_op=00 in EXEC_R.
- lw (100011) -> states 0,1,2,3,4. mem_read=1 with i_or_d=1 in MEM_RD. MEM_WB has mem_to_reg=1, reg_write=1. instr_done exactly once, 5 cycles total.
- sw then beq then j -> sw: mem_write=1 in state 5. beq: pc_write_cond=1, pc_source=01, alu_op=01. j: pc_write=1, pc_source=10. Each returns to FETCH.
- ori (001101) and lui (001111) -> EXEC_I gives ext_op=00/alu_op=10 and ext_op=10/alu_op=11 respectively. WB_I has reg_dst=0.
- opcode=111111 with HALT_ON_ILLEGAL=1 -> illegal=1, state_o=15, held for 20 cycles. rst_n pulse clears illegal and returns to FETCH.
- MULTICYCLE_MEM_WAIT_EN defined, lw with mem_ready low 3 cycles in FETCH and 2 in MEM_RD -> lw takes 10 cycles. ir_write pulses once. rst_n asserted mid-wait forces all outputs to 0 immediately.
